// File: rtl/dual_port_ram_bist_if.sv
// RAM-side bus of the BIST: write port, read port and registered read data.
// The master (BIST) drives addresses/data; the slave (RAM) returns mem_out one cycle after mem_rd.
interface dual_port_ram_bist_if;
    logic        mem_wr;
    logic [11:0] mem_wr_add;
    logic [63:0] mem_in;
    logic        mem_rd;
    logic [11:0] mem_rd_add;
    logic [63:0] mem_out;

    modport master (
        output mem_wr, mem_wr_add, mem_in, mem_rd, mem_rd_add,
        input  mem_out
    );

    modport slave (
        input  mem_wr, mem_wr_add, mem_in, mem_rd, mem_rd_add,
        output mem_out
    );
endinterface

// File: rtl/dual_port_ram_bist.sv
// Two-pass write/read-compare march BIST for a 4096 x 64 dual-port RAM.
// Latency: done 4N+3 cycles after start (N = DEPTH_LAST+1); no backpressure, one access per cycle.
module dual_port_ram_bist #(
    parameter int unsigned DEPTH_LAST   = 4095,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    dual_port_ram_bist_if.master        mem,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [13:0]                 err_cnt,
    output logic                        first_fail_pass,
    output logic [11:0]                 first_fail_add,
    output logic [63:0]                 first_fail_data
);

    localparam logic [11:0] LAST_ADD = 12'(DEPTH_LAST);

    // Encoding order matters: each phase's successor is state + 1.
    typedef enum logic [2:0] {IDLE, WR0, RD0, DRN0, WR1, RD1, DRN1, DONE} state_t;

    function automatic logic [63:0] pattern(input logic [11:0] a, input logic inv);
        return {4{4'hA, a}} ^ {64{inv}};
    endfunction

    state_t      state_q, state_d;
    logic [11:0] add_q, add_d;
    logic        cmp_vld_q, cmp_vld_d;
    logic [11:0] cmp_add_q, cmp_add_d;
    logic        cmp_inv_q, cmp_inv_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [13:0] err_cnt_q, err_cnt_d;
    logic        ffp_q, ffp_d;
    logic [11:0] ffa_q, ffa_d;
    logic [63:0] ffd_q, ffd_d;
    logic        mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
    logic [11:0] mem_wr_add_q, mem_wr_add_d, mem_rd_add_q, mem_rd_add_d;
    logic [63:0] mem_in_q, mem_in_d;
    logic        last, mismatch;

    always_comb begin
        state_d   = state_q;
        add_d     = add_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        ffp_d     = ffp_q;
        ffa_d     = ffa_q;
        ffd_d     = ffd_q;
        // Expected-value pipeline travels alongside the read issued this cycle.
        cmp_vld_d = (state_q == RD0) || (state_q == RD1);
        cmp_add_d = add_q;
        cmp_inv_d = (state_q == RD1);
        last      = (add_q == LAST_ADD);
        mismatch  = cmp_vld_q && (mem.mem_out != pattern(cmp_add_q, cmp_inv_q));

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = WR0;
                    add_d     = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_cnt_d = '0;
                    ffp_d     = 1'b0;
                    ffa_d     = '0;
                    ffd_d     = '0;
                end
            end
            WR0, RD0, WR1, RD1: begin
                add_d = last ? 12'd0 : add_q + 12'd1;
                if (last) state_d = state_t'(state_q + 3'd1);
            end
            DRN0, DRN1: state_d = state_t'(state_q + 3'd1);
            default:    state_d = IDLE;
        endcase

        if (mismatch) begin
            err_cnt_d = err_cnt_q + 14'd1;
            if (err_cnt_q == '0) begin
                ffp_d = cmp_inv_q;
                ffa_d = cmp_add_q;
                ffd_d = mem.mem_out;
            end
            // Reads still in flight are dropped so they cannot count.
            if (STOP_ON_FAIL) begin
                state_d   = DONE;
                cmp_vld_d = 1'b0;
            end
        end

        if ((state_d == DONE) && (state_q != DONE)) begin
            done_d = 1'b1;
            pass_d = (err_cnt_d == '0);
        end

        busy_d       = (state_d != IDLE) && (state_d != DONE);
        mem_wr_d     = (state_d == WR0) || (state_d == WR1);
        mem_rd_d     = (state_d == RD0) || (state_d == RD1);
        mem_wr_add_d = mem_wr_d ? add_d : 12'd0;
        mem_in_d     = mem_wr_d ? pattern(add_d, state_d == WR1) : 64'd0;
        mem_rd_add_d = mem_rd_d ? add_d : 12'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            add_q        <= '0;
            cmp_vld_q    <= 1'b0;
            cmp_add_q    <= '0;
            cmp_inv_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            ffp_q        <= 1'b0;
            ffa_q        <= '0;
            ffd_q        <= '0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_add_q <= '0;
            mem_rd_add_q <= '0;
            mem_in_q     <= '0;
        end else begin
            state_q      <= state_d;
            add_q        <= add_d;
            cmp_vld_q    <= cmp_vld_d;
            cmp_add_q    <= cmp_add_d;
            cmp_inv_q    <= cmp_inv_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            ffp_q        <= ffp_d;
            ffa_q        <= ffa_d;
            ffd_q        <= ffd_d;
            mem_wr_q     <= mem_wr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_add_q <= mem_wr_add_d;
            mem_rd_add_q <= mem_rd_add_d;
            mem_in_q     <= mem_in_d;
        end
    end

    assign mem.mem_wr      = mem_wr_q;
    assign mem.mem_wr_add  = mem_wr_add_q;
    assign mem.mem_in      = mem_in_q;
    assign mem.mem_rd      = mem_rd_q;
    assign mem.mem_rd_add  = mem_rd_add_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign first_fail_pass = ffp_q;
    assign first_fail_add  = ffa_q;
    assign first_fail_data = ffd_q;

endmodule

// File: tb/tb_dual_port_ram_bist.sv
// Directed bench: three BIST instances (short clean/faulty, short stop-on-fail, full depth) each with a RAM model.
// RAM models can force read bit 0 to 0 to emulate a stuck-at fault.
module tb_dual_port_ram_bist;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    dual_port_ram_bist_if a_if ();
    dual_port_ram_bist_if b_if ();
    dual_port_ram_bist_if c_if ();

    logic start_a, start_b, start_c;
    logic fault_a, fault_c;
    logic        a_busy, a_done, a_pass, a_ffp, b_busy, b_done, b_pass, b_ffp, c_busy, c_done, c_pass, c_ffp;
    logic [13:0] a_err, b_err, c_err;
    logic [11:0] a_ffa, b_ffa, c_ffa;
    logic [63:0] a_ffd, b_ffd, c_ffd;

    dual_port_ram_bist #(.DEPTH_LAST(15), .STOP_ON_FAIL(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mem(a_if),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err),
        .first_fail_pass(a_ffp), .first_fail_add(a_ffa), .first_fail_data(a_ffd));

    dual_port_ram_bist #(.DEPTH_LAST(15), .STOP_ON_FAIL(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mem(b_if),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err),
        .first_fail_pass(b_ffp), .first_fail_add(b_ffa), .first_fail_data(b_ffd));

    dual_port_ram_bist u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .mem(c_if),
        .busy(c_busy), .done(c_done), .pass(c_pass), .err_cnt(c_err),
        .first_fail_pass(c_ffp), .first_fail_add(c_ffa), .first_fail_data(c_ffd));

    // RAM models: registered read data, zero when no read was issued.
    logic [63:0] ram_a [4096];
    logic [63:0] ram_b [4096];
    logic [63:0] ram_c [4096];

    always @(posedge clk) begin
        if (a_if.mem_wr) ram_a[a_if.mem_wr_add] <= a_if.mem_in;
        a_if.mem_out <= a_if.mem_rd ? (ram_a[a_if.mem_rd_add] & ~{63'd0, fault_a}) : 64'd0;
        if (b_if.mem_wr) ram_b[b_if.mem_wr_add] <= b_if.mem_in;
        b_if.mem_out <= b_if.mem_rd ? (ram_b[b_if.mem_rd_add] & ~64'd1) : 64'd0;
        if (c_if.mem_wr) ram_c[c_if.mem_wr_add] <= c_if.mem_in;
        c_if.mem_out <= c_if.mem_rd ? (ram_c[c_if.mem_rd_add] & ~{63'd0, fault_c}) : 64'd0;
    end

    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0, both_hi = 0;
    logic [63:0] cap3 [$];

    always @(negedge clk) begin
        if (a_if.mem_wr) wr_a++;
        if (a_if.mem_rd) rd_a++;
        if (b_if.mem_wr) wr_b++;
        if (b_if.mem_rd) rd_b++;
        if ((a_if.mem_wr && a_if.mem_rd) || (b_if.mem_wr && b_if.mem_rd) || (c_if.mem_wr && c_if.mem_rd))
            both_hi++;
        if (a_if.mem_wr && a_if.mem_wr_add == 12'd3) cap3.push_back(a_if.mem_in);
    end

    int wr_base, rd_base, n3;

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        fault_a = 1'b0; fault_c = 1'b0;
        tick(3);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_err", a_err, 0);
        chk("rst_mem_wr", a_if.mem_wr, 0);
        chk("rst_mem_rd", a_if.mem_rd, 0);
        chk("rst_ffd", a_ffd, 0);
        rst_n = 1'b1;
        tick(1);

        // Clean run, start pulses at cycles 5 and 40 must be ignored.
        wr_base = wr_a; rd_base = rd_a; n3 = cap3.size();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        chk("c1_busy", a_busy, 1);
        chk("c1_mem_wr", a_if.mem_wr, 1);
        chk("c1_wr_add", a_if.mem_wr_add, 0);
        chk("c1_mem_in", a_if.mem_in, 64'hA000A000A000A000);
        tick(4);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(12);
        chk("c18_mem_rd", a_if.mem_rd, 1);
        chk("c18_rd_add", a_if.mem_rd_add, 1);
        tick(15);
        chk("drn0_mem_wr", a_if.mem_wr, 0);
        chk("drn0_mem_rd", a_if.mem_rd, 0);
        chk("drn0_busy", a_busy, 1);
        tick(1);
        chk("c34_mem_wr", a_if.mem_wr, 1);
        chk("c34_wr_add", a_if.mem_wr_add, 0);
        chk("c34_mem_in", a_if.mem_in, 64'h5FFF5FFF5FFF5FFF);
        tick(6);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(25);
        chk("c66_done", a_done, 0);
        tick(1);
        chk("c67_done", a_done, 1);
        chk("c67_busy", a_busy, 0);
        chk("c67_pass", a_pass, 1);
        chk("c67_err", a_err, 0);
        chk("wr_cycles", wr_a - wr_base, 32);
        chk("rd_cycles", rd_a - rd_base, 32);
        chk("cap3_count", cap3.size() - n3, 2);
        chk("cap3_p0", (cap3.size() > n3) ? cap3[n3] : 64'hx, 64'hA003A003A003A003);
        chk("cap3_p1", (cap3.size() > n3 + 1) ? cap3[n3 + 1] : 64'hx, 64'h5FFC5FFC5FFC5FFC);

        // Stuck-at-0 on read bit 0, started from DONE.
        fault_a = 1'b1;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        chk("f_clr_done", a_done, 0);
        chk("f_clr_pass", a_pass, 0);
        tick(66);
        chk("f_done", a_done, 1);
        chk("f_pass", a_pass, 0);
        chk("f_err", a_err, 16);
        chk("f_ffp", a_ffp, 0);
        chk("f_ffa", a_ffa, 1);
        chk("f_ffd", a_ffd, 64'hA001A001A001A000);

        // Restart clears error state, then reset in cycle 10.
        fault_a = 1'b0;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        chk("r_clr_err", a_err, 0);
        chk("r_clr_ffa", a_ffa, 0);
        chk("r_clr_ffd", a_ffd, 0);
        chk("r_clr_done", a_done, 0);
        tick(9);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("r11_busy", a_busy, 0);
        chk("r11_mem_wr", a_if.mem_wr, 0);
        chk("r11_wr_add", a_if.mem_wr_add, 0);
        chk("r11_mem_in", a_if.mem_in, 0);
        chk("r11_mem_rd", a_if.mem_rd, 0);
        chk("r11_done", a_done, 0);
        wr_base = wr_a; rd_base = rd_a;
        tick(20);
        chk("r_no_access", (wr_a - wr_base) + (rd_a - rd_base), 0);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(66);
        chk("r_done", a_done, 1);
        chk("r_pass", a_pass, 1);
        chk("r_err", a_err, 0);

        // Stop-on-fail with the same fault.
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        tick(17);
        chk("s18_mem_rd", b_if.mem_rd, 1);
        chk("s18_rd_add", b_if.mem_rd_add, 1);
        tick(1);
        chk("s19_rd_add", b_if.mem_rd_add, 2);
        chk("s19_done", b_done, 0);
        tick(1);
        chk("s20_done", b_done, 1);
        chk("s20_busy", b_busy, 0);
        chk("s20_err", b_err, 1);
        chk("s20_pass", b_pass, 0);
        chk("s20_mem_rd", b_if.mem_rd, 0);
        chk("s20_mem_wr", b_if.mem_wr, 0);
        chk("s20_ffa", b_ffa, 1);
        chk("s20_ffd", b_ffd, 64'hA001A001A001A000);
        wr_base = wr_b; rd_base = rd_b;
        tick(3);
        chk("s23_err", b_err, 1);
        chk("s_no_access", (wr_b - wr_base) + (rd_b - rd_base), 0);

        // Full depth: faulty run, then clean back-to-back run from DONE.
        fault_c = 1'b1;
        start_c = 1'b1;
        tick(1);
        start_c = 1'b0;
        tick(16385);
        chk("full_f_c16386_done", c_done, 0);
        tick(1);
        chk("full_f_done", c_done, 1);
        chk("full_f_err", c_err, 4096);
        chk("full_f_pass", c_pass, 0);
        chk("full_f_ffa", c_ffa, 1);
        chk("full_f_ffp", c_ffp, 0);
        fault_c = 1'b0;
        start_c = 1'b1;
        tick(1);
        start_c = 1'b0;
        chk("b2b_clr_done", c_done, 0);
        chk("b2b_clr_err", c_err, 0);
        chk("b2b_busy", c_busy, 1);
        tick(16385);
        chk("b2b_c16386_done", c_done, 0);
        tick(1);
        chk("b2b_done", c_done, 1);
        chk("b2b_pass", c_pass, 1);
        chk("b2b_err", c_err, 0);

        chk("wr_rd_overlap", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_bist.md
# dual_port_ram_bist

Built-in self-test initiator for the 4096 x 64 dual-port RAM. It drives the RAM's write and read ports, running a two-pass write/read-compare march over the address range. It checks every word against an address-derived pattern and its inverse, and reports pass/fail, the error count and the first failing location. It sits beside the RAM in test mode and owns both of the RAM's ports while busy.

## Interface
- DEPTH_LAST, default 4095: last address tested; the range is 0..DEPTH_LAST, N = DEPTH_LAST+1. Legal values are 0..4095.
- STOP_ON_FAIL, default 0: when 1, the test ends at the first mismatch.

- clk  in  1  clock; all logic on its rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle test request; accepted only when not busy
- mem_wr  out  1  RAM write enable
- mem_wr_add  out  12  RAM write address
- mem_in  out  64  RAM write data
- mem_rd  out  1  RAM read enable
- mem_rd_add  out  12  RAM read address
- mem_out  in  64  RAM read data; registered, valid the cycle after mem_rd, 0 when mem_rd was low
- busy  out  1  test in progress
- done  out  1  test finished; held until next accepted start or reset
- pass  out  1  valid when done; 1 means zero mismatches
- err_cnt  out  14  mismatch count, 0..8192; cannot overflow
- first_fail_pass  out  1  pass index (0/1) of the first mismatch
- first_fail_add  out  12  address of the first mismatch
- first_fail_data  out  64  data read at the first mismatch

## Operation
- Patterns: pat0(a) = {4{4'hA, a[11:0]}}; pat1(a) = ~pat0(a).
- States and transitions:
  - IDLE -> WR0 on start.
  - WR0: write pat0(a) to a = 0..N-1, one write per cycle.
  - RD0: issue reads a = 0..N-1, one per cycle.
  - DRN0: one cycle, no read issued; the last compare of pass 0 happens here.
  - WR1: write pat1(a) to a = 0..N-1.
  - RD1: issue reads a = 0..N-1.
  - DRN1: one cycle; last compare of pass 1.
  - DONE: DONE -> WR0 on start.
- Compare: a read issued in cycle t is compared in cycle t+1 against an expected value pipelined with it. A mismatch increments err_cnt. The first mismatch since start also captures first_fail_pass, first_fail_add and first_fail_data.
- STOP_ON_FAIL=1: on a mismatch, the next state is DONE regardless of phase. Data from reads still in flight is ignored and not counted.
- pass is set on entering DONE: pass = (err_cnt == 0 including the final compare).
- Accepted start in IDLE or DONE:
  - clears done, pass, err_cnt and the first_fail_* fields;
  - sets busy;
  - RAM contents before the test are irrelevant.
- start while busy is ignored.
- mem_wr and mem_rd are never high in the same cycle.
- Outside WR states, mem_wr=0, mem_wr_add=0 and mem_in=0. Outside RD states, mem_rd=0 and mem_rd_add=0.
- Address counter: runs 0..DEPTH_LAST, then resets to 0 on phase change. It never wraps past DEPTH_LAST.

## Timing
- All outputs are registered. Reset value of every output is 0; state goes to IDLE.
- Reset mid-test: on the next cycle all outputs are 0 and state is IDLE; no further RAM accesses occur.
- Take start high in cycle 0 as the reference:
  - busy=1 and mem_wr=1 with mem_wr_add=0 in cycle 1.
  - WR0 occupies cycles 1..N.
  - RD0 occupies N+1..2N.
  - DRN0 is cycle 2N+1.
  - WR1 occupies 2N+2..3N+1.
  - RD1 occupies 3N+2..4N+1.
  - DRN1 is cycle 4N+2.
  - done=1, busy=0 and pass valid from cycle 4N+3.
- Full depth: done at cycle 16387.
- Error registers update at the end of the compare cycle and are visible the cycle after.
- STOP_ON_FAIL: with the mismatch compared in cycle t, state is DONE and done=1 in cycle t+1, with err_cnt already updated.

## Test plan
- Fault-free RAM, DEPTH_LAST=15, start at cycle 0:
  - done=1 at cycle 67, pass=1, err_cnt=0;
  - mem_wr high exactly 32 cycles, mem_rd high exactly 32 cycles;
  - mem_in at address 3 is 64'hA003A003A003A003 in pass 0 and 64'h5FFC5FFC5FFC5FFC in pass 1.
- RAM model with mem_out bit 0 stuck at 0, DEPTH_LAST=15:
  - err_cnt=16 (odd addresses in pass 0, even in pass 1), pass=0;
  - first_fail_pass=0, first_fail_add=1, first_fail_data=64'hA001A001A001A000.
- Same fault with STOP_ON_FAIL=1:
  - address 1 read issued cycle 18, compared cycle 19;
  - done=1 at cycle 20 with err_cnt=1, pass=0;
  - mem_rd=0 and mem_wr=0 from cycle 20.
- start pulses at cycles 5 and 40 during a DEPTH_LAST=15 run: both ignored; done still at cycle 67.
- rst_n low in cycle 10 of a run:
  - all outputs 0 in cycle 11, no RAM access afterwards;
  - a fresh start completes normally with pass=1.
- Back-to-back runs: a first run with a fault, fault removed, then start in DONE:
  - done, pass and err_cnt clear the next cycle;
  - the second run ends with pass=1, err_cnt=0;
  - default DEPTH_LAST: done at cycle 16387.
